// File: rtl/mdu_iter.sv
// mdu_iter: iterative RISC-V M-extension multiply/divide unit.
// Handles one operation at a time. Multiply uses shift-add and divide uses
// restoring division, one bit per cycle on unsigned magnitudes, with a sign
// fix-up at the end.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   request handshake (in_ready high only when idle)
//   op[2:0]               funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   rs1_data, rs2_data    dividend/multiplicand, divisor/multiplier
//   flush                 synchronous kill of in-flight or held result
//   out_valid / out_ready result handshake
//   result                registered result
module mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN + 1);

  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_MULH = 3'b001;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic            neg_q, neg_d;
  logic            spec_q, spec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;

  // Request decode: signedness, magnitudes, result sign, special divides
  logic            is_div, sgn_a, sgn_b, a_neg, b_neg, res_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    is_div   = op[2];
    sgn_a    = ~op[0] | (op == OP_MULH);
    sgn_b    = op[2] ? ~op[0] : ~op[1];
    a_neg    = sgn_a & rs1_data[XLEN-1];
    b_neg    = sgn_b & rs2_data[XLEN-1];
    a_mag    = a_neg ? (~rs1_data + XLEN'(1)) : rs1_data;
    b_mag    = b_neg ? (~rs2_data + XLEN'(1)) : rs2_data;
    // Remainder takes the dividend sign; everything else is the XOR
    res_neg  = (is_div & op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div & (rs2_data == '0);
    div_ovf  = is_div & ~op[0] & (rs1_data == MOST_NEG) & (rs2_data == '1);
    if (div_zero) spec_res = op[1] ? rs1_data : '1;
    else          spec_res = op[1] ? '0 : MOST_NEG;
  end

  // One iteration step: shift-add multiply and restoring divide
  logic [XLEN:0]   mul_sum;
  logic [W2-1:0]   mul_next;
  logic [XLEN:0]   div_part, div_diff;
  logic [W2-1:0]   div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_part = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_part - {1'b0, opnd_q};
    div_next = {(div_diff[XLEN] ? div_part[XLEN-1:0] : div_diff[XLEN-1:0]),
                acc_q[XLEN-2:0], ~div_diff[XLEN]};
  end

  // Final result with sign fix-up; special cases carry their answer in acc
  logic [W2-1:0]   prod;
  logic [XLEN-1:0] mul_res, div_raw, div_res, fin_res;

  always_comb begin
    prod    = neg_q ? (~acc_q + W2'(1)) : acc_q;
    mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
    div_raw = op_q[1] ? acc_q[W2-1:XLEN] : acc_q[XLEN-1:0];
    div_res = neg_q ? (~div_raw + XLEN'(1)) : div_raw;
    if (spec_q)       fin_res = acc_q[XLEN-1:0];
    else if (op_q[2]) fin_res = div_res;
    else              fin_res = mul_res;
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    spec_d      = spec_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;

    if (flush) begin
      state_d     = S_IDLE;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d       = op;
            neg_d      = res_neg;
            in_ready_d = 1'b0;
            state_d    = S_CALC;
            if (div_zero || div_ovf) begin
              // Zero iteration steps: one cycle in CALC, then DONE
              spec_d = 1'b1;
              acc_d  = {XLEN'(0), spec_res};
              opnd_d = '0;
              cnt_d  = '0;
            end else begin
              spec_d = 1'b0;
              opnd_d = is_div ? b_mag : a_mag;
              acc_d  = {XLEN'(0), (is_div ? a_mag : b_mag)};
              cnt_d  = CW'(XLEN);
            end
          end
        end
        S_CALC: begin
          if (cnt_q != '0) begin
            acc_d = op_q[2] ? div_next : mul_next;
            cnt_d = cnt_q - CW'(1);
          end else begin
            result_d    = fin_res;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
          end
        end
        default: begin
          state_d     = S_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      spec_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      spec_q      <= spec_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vector table plus hand-written multi-cycle sequences
// (backpressure, flush, reset abort) and a model-checked random section.
module tb_mdu_iter;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  int errors = 0;
  int checks = 0;

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    r  = '0;
    case (o)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'b0, b})); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
        else r = 32'(sa / sb);
      end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Wait for in_ready (bounded), then present one request for one edge
  task automatic accept(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; rs1_data = a; rs2_data = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid rises (bounded)
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
    int n;
    accept(o, a, b, tag);
    check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    wait_valid(n);
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " result"}, result, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          n;
    int          seen;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          rl;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[2]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
    vecs[14] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[15] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
    vecs[16] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        33};
    vecs[17] = '{3'd5, 32'd0,        32'd5,        32'd0,        33};

    rst_n = 1'b0; in_valid = 1'b0; op = '0; rs1_data = '0; rs2_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
            $sformatf("vec%0d", i));
    end

    // Backpressure: result held 5 cycles, new request ignored
    accept(3'd5, 32'd100, 32'd7, "bp");
    wait_valid(n);
    check("bp latency", 32'(n), 32'd33);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2); op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd3;
      @(posedge clk); #1;
      check($sformatf("bp result hold %0d", k), result, 32'd14);
      check($sformatf("bp in_ready hold %0d", k), 32'(in_ready), 32'd0);
      check($sformatf("bp out_valid hold %0d", k), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "bp next");

    // Flush on CALC step 10
    accept(3'd0, 32'd7, 32'hFFFFFFFD, "fl");
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl in_ready", 32'(in_ready), 32'd1);
    check("fl out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("fl no out_valid later", 32'(seen), 32'd0);
    check("fl result unchanged", result, 32'd2);
    // flush beats in_valid in IDLE
    in_valid = 1'b1; flush = 1'b1; op = 3'd0; rs1_data = 32'd2; rs2_data = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("fl suppresses accept", 32'(in_ready), 32'd1);
    do_op(3'd0, 32'd6, 32'd7, 32'd42, 33, "fl next");

    // Flush while holding a result in DONE
    accept(3'd5, 32'd9, 32'd0, "fld");
    wait_valid(n);
    flush = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fld out_valid", 32'(out_valid), 32'd0);
    check("fld in_ready", 32'(in_ready), 32'd1);

    // Async reset mid-CALC
    accept(3'd3, 32'd1000, 32'd1000, "rs");
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("rs in_ready", 32'(in_ready), 32'd1);
    check("rs out_valid", 32'(out_valid), 32'd0);
    check("rs result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(3'd4, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33, "rs next");

    // Random regression against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: rb = 32'd0;
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        default: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
      endcase
      rl = (ro[2] && (rb == 0 || (!ro[0] && ra == 32'h80000000 && rb == 32'hFFFFFFFF))) ? 1 : 33;
      do_op(ro, ra, rb, ref_model(ro, ra, rb), rl, $sformatf("rnd%0d op%0d", i, ro));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
